sdram_bist: RTL and testbench

- Built-in self-test traffic generator that sits directly upstream of sdram_core_pc.
- It drives the core's request/response channel in place of axil_sdram whenever the test is selected; the top-level mux is outside this block.
- It writes a deterministic pattern over a word range, reads the range back with bounded outstanding reads, and compares the data.
- It reports pass/fail, an error count and the first failing address/data.

---
 rtl/sdram_bist.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sdram_bist.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist.sv
// Built-in self-test traffic generator for sdram_core_pc: writes a seeded pattern over a
// word range, reads it back with a bounded number of outstanding reads and compares.
module sdram_bist #(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    NUM_WORDS       = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                    MAX_OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [DATA_WIDTH-1:0]     seed,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic                      req_we,
   output logic [ADDR_WIDTH-1:0]     req_addr,
   output logic [DATA_WIDTH-1:0]     req_wdata,
   output logic [DATA_WIDTH/8-1:0]   req_wstrb,
   input  logic                      rsp_valid,
   input  logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [15:0]               err_count,
   output logic [ADDR_WIDTH-1:0]     first_err_addr,
   output logic [DATA_WIDTH-1:0]     first_err_data
);

   localparam int H      = DATA_WIDTH / 2;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_WORDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [3:0]       MAX_OUT  = 4'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE, S_ABORT} state_t;

   function automatic logic [DATA_WIDTH-1:0] pat_f(input logic [DATA_WIDTH-1:0] s,
                                                   input logic [IDX_W-1:0] idx);
      logic [H-1:0] ih;
      ih = H'(idx);
      return s ^ {~ih, ih};
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] addr_f(input logic [IDX_W-1:0] idx);
      return BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(STRB_W);
   endfunction

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        ci_q, ci_d;
   logic [3:0]              out_cnt_q, out_cnt_d;
   logic [DATA_WIDTH-1:0]   seed_q, seed_d;
   logic                    abort_q, abort_d;
   logic                    req_valid_q, req_valid_d;
   logic                    req_we_q, req_we_d;
   logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
   logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
   logic [STRB_W-1:0]       req_wstrb_q, req_wstrb_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [15:0]             err_count_q, err_count_d;
   logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
   logic [DATA_WIDTH-1:0]   first_err_data_q, first_err_data_d;

   logic acc, rd_acc, rsp_ok, abort_now;

   assign acc       = req_valid_q & req_ready;
   assign rd_acc    = acc & ~req_we_q;
   assign rsp_ok    = rsp_valid & (out_cnt_q != 4'd0);
   assign abort_now = abort | abort_q;

   // Next-state, request and result computation
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      ci_d             = ci_q;
      seed_d           = seed_q;
      abort_d          = abort_q;
      req_valid_d      = req_valid_q;
      req_we_d         = req_we_q;
      req_addr_d       = req_addr_q;
      req_wdata_d      = req_wdata_q;
      req_wstrb_d      = req_wstrb_q;
      busy_d           = busy_q;
      done_d           = done_q;
      pass_d           = pass_q;
      err_count_d      = err_count_q;
      first_err_addr_d = first_err_addr_q;
      first_err_data_d = first_err_data_q;
      out_cnt_d        = out_cnt_q + {3'b000, rd_acc} - {3'b000, rsp_ok};

      // Responses are in order, so the compare index simply follows them
      if (rsp_ok) begin
         ci_d = ci_q + IDX_W'(1);
         if (rsp_rdata != pat_f(seed_q, ci_q)) begin
            if (err_count_q != 16'hFFFF) begin
               err_count_d = err_count_q + 16'd1;
            end else begin
               err_count_d = err_count_q;
            end
            if (err_count_q == 16'd0) begin
               first_err_addr_d = addr_f(ci_q);
               first_err_data_d = rsp_rdata;
            end else begin
               first_err_addr_d = first_err_addr_q;
            end
         end else begin
            err_count_d = err_count_q;
         end
      end else begin
         ci_d = ci_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d           = seed;
               abort_d          = 1'b0;
               idx_d            = '0;
               ci_d             = '0;
               busy_d           = 1'b1;
               done_d           = 1'b0;
               pass_d           = 1'b0;
               err_count_d      = 16'd0;
               first_err_addr_d = '0;
               first_err_data_d = '0;
               req_valid_d      = 1'b1;
               req_we_d         = 1'b1;
               req_addr_d       = addr_f('0);
               req_wdata_d      = pat_f(seed, '0);
               req_wstrb_d      = '1;
               state_d          = S_WR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            abort_d = abort_now;
            if (acc) begin
               if (abort_now) begin
                  req_valid_d = 1'b0;
                  state_d     = S_ABORT;
               end else if (idx_q == LAST_IDX) begin
                  // Nothing is outstanding yet, so the first read can go out at once
                  idx_d       = '0;
                  req_we_d    = 1'b0;
                  req_addr_d  = addr_f('0);
                  req_valid_d = 1'b1;
                  state_d     = S_RD;
               end else begin
                  idx_d       = idx_q + IDX_W'(1);
                  req_addr_d  = addr_f(idx_q + IDX_W'(1));
                  req_wdata_d = pat_f(seed_q, idx_q + IDX_W'(1));
               end
            end else begin
               req_valid_d = 1'b1;
            end
         end
         S_RD: begin
            abort_d = abort_now;
            if (acc) begin
               idx_d      = idx_q + IDX_W'(1);
               req_addr_d = addr_f(idx_q + IDX_W'(1));
               if (abort_now) begin
                  req_valid_d = 1'b0;
                  state_d     = S_ABORT;
               end else if (idx_q == LAST_IDX) begin
                  req_valid_d = 1'b0;
                  state_d     = S_DRAIN;
               end else begin
                  req_valid_d = (out_cnt_d < MAX_OUT);
               end
            end else if (!req_valid_q) begin
               if (abort_now) begin
                  state_d = S_ABORT;
               end else begin
                  req_valid_d = (out_cnt_d < MAX_OUT);
               end
            end else begin
               req_valid_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (out_cnt_q == 4'd0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            pass_d  = (err_count_q == 16'd0);
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ABORT: begin
            if (out_cnt_q == 4'd0) begin
               busy_d  = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               abort_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_ABORT;
            end
         end
         default: begin
            req_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         ci_q             <= '0;
         out_cnt_q        <= 4'd0;
         seed_q           <= '0;
         abort_q          <= 1'b0;
         req_valid_q      <= 1'b0;
         req_we_q         <= 1'b0;
         req_addr_q       <= '0;
         req_wdata_q      <= '0;
         req_wstrb_q      <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_count_q      <= 16'd0;
         first_err_addr_q <= '0;
         first_err_data_q <= '0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         ci_q             <= ci_d;
         out_cnt_q        <= out_cnt_d;
         seed_q           <= seed_d;
         abort_q          <= abort_d;
         req_valid_q      <= req_valid_d;
         req_we_q         <= req_we_d;
         req_addr_q       <= req_addr_d;
         req_wdata_q      <= req_wdata_d;
         req_wstrb_q      <= req_wstrb_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         err_count_q      <= err_count_d;
         first_err_addr_q <= first_err_addr_d;
         first_err_data_q <= first_err_data_d;
      end
   end

   assign req_valid      = req_valid_q;
   assign req_we         = req_we_q;
   assign req_addr       = req_addr_q;
   assign req_wdata      = req_wdata_q;
   assign req_wstrb      = req_wstrb_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign first_err_addr = first_err_addr_q;
   assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist: a small word memory with configurable ready duty and
// fixed read latency answers the generator; results are compared with hand-computed values.
module tb_sdram_bist;

   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          NW   = 16;
   localparam int          MO   = 4;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [DW-1:0] seed;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_wstrb;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;

   sdram_bist #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
      .BASE_ADDR(BASE), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   logic [31:0] mem [NW];
   rsp_t        rq[$];
   int          n_checks, n_pass;
   int          cyc, outst, max_out, n_wr, n_rd, n_rsp, stab_err, bad_addr;
   int          ready_pct, lat, corrupt_idx, used;
   logic        inject, start_req, abort_arm, stalled, sv_we;
   logic [31:0] wd3, sv_addr, sv_wdata;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic reset_model();
      rq.delete();
      outst    = 0;
      max_out  = 0;
      n_wr     = 0;
      n_rd     = 0;
      n_rsp    = 0;
      stab_err = 0;
      bad_addr = 0;
      stalled  = 1'b0;
      wd3      = 32'h0;
   endtask

   // One clock: drive inputs at the falling edge, model the handshake at the next rising edge
   task automatic tick();
      int   idx;
      rsp_t e;
      @(negedge clk);
      cyc++;
      start     = start_req;
      start_req = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'h0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_rdata = rq[0].data;
         rq.delete(0);
         outst--;
         n_rsp++;
      end else if (inject) begin
         rsp_valid = 1'b1;
         rsp_rdata = 32'hDEAD_BEEF;
         inject    = 1'b0;
      end
      req_ready = ($urandom_range(0, 99) < ready_pct);
      if (stalled && (!req_valid || req_addr !== sv_addr || req_wdata !== sv_wdata
                      || req_we !== sv_we)) stab_err++;
      if (abort_arm && req_valid && !req_we && req_ready && outst == 2) begin
         abort     = 1'b1;
         abort_arm = 1'b0;
      end
      if (req_valid && req_ready) begin
         idx = int'((req_addr - BASE) >> 2);
         if (idx < 0 || idx >= NW) begin
            bad_addr++;
         end else if (req_we) begin
            mem[idx] = req_wdata;
            n_wr++;
            if (idx == 3) wd3 = req_wdata;
         end else begin
            e.data = mem[idx] ^ ((idx == corrupt_idx) ? 32'h1 : 32'h0);
            e.due  = cyc + lat;
            rq.push_back(e);
            outst++;
            n_rd++;
         end
         stalled = 1'b0;
      end else begin
         stalled = req_valid;
      end
      if (outst > max_out) max_out = outst;
      sv_addr  = req_addr;
      sv_wdata = req_wdata;
      sv_we    = req_we;
   endtask

   task automatic run_to_idle(input logic [31:0] s, input int budget);
      seed      = s;
      start_req = 1'b1;
      tick();
      used = 0;
      do begin
         tick();
         used++;
      end while (busy && used < budget);
      chk_eq("run_ends", busy, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 32'h0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
      inject = 1'b0; start_req = 1'b0; abort_arm = 1'b0;
      ready_pct = 100; lat = 1; corrupt_idx = -1;
      for (int i = 0; i < NW; i++) mem[i] = 32'h0;
      reset_model();
      repeat (3) tick();
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      chk_eq("rst_pass", pass, 1'b0);
      chk_eq("rst_req_valid", req_valid, 1'b0);
      chk_eq("rst_wstrb", req_wstrb, 4'h0);
      chk_eq("rst_err_count", err_count, 16'h0);
      chk_eq("rst_first_addr", first_err_addr, 32'h0);
      rst_n = 1'b1;
      tick();

      // Ideal memory, single-cycle response
      reset_model();
      run_to_idle(32'hA5A5_0000, 200);
      chk_eq("t1_writes", n_wr, 16);
      chk_eq("t1_reads", n_rd, 16);
      chk_eq("t1_wdata3", wd3, 32'h5A59_0003);
      chk_eq("t1_done", done, 1'b1);
      chk_eq("t1_pass", pass, 1'b1);
      chk_eq("t1_err", err_count, 16'h0);
      chk_eq("t1_wstrb", req_wstrb, 4'hF);
      chk_eq("t1_latency_ok", (used <= 40), 1'b1);
      repeat (3) tick();
      chk_eq("t1_done_held", done, 1'b1);

      // Word 5 corrupted on read
      reset_model();
      corrupt_idx = 5;
      run_to_idle(32'hA5A5_0000, 200);
      chk_eq("t2_err", err_count, 16'h1);
      chk_eq("t2_first_addr", first_err_addr, 32'h0000_0114);
      chk_eq("t2_first_data", first_err_data, 32'h5A5F_0004);
      chk_eq("t2_pass", pass, 1'b0);
      chk_eq("t2_done", done, 1'b1);
      corrupt_idx = -1;

      // Sparse ready, long read latency
      reset_model();
      ready_pct = 30;
      lat       = 6;
      run_to_idle(32'h1234_5678, 3000);
      chk_eq("t3_max_out_le4", (max_out <= MO), 1'b1);
      chk_eq("t3_stable", stab_err, 0);
      chk_eq("t3_bad_addr", bad_addr, 0);
      chk_eq("t3_reads", n_rd, 16);
      chk_eq("t3_pass", pass, 1'b1);
      chk_eq("t3_err", err_count, 16'h0);

      // Mid-run start and a stray response with nothing outstanding
      reset_model();
      ready_pct = 100;
      lat       = 1;
      seed      = 32'hA5A5_0000;
      start_req = 1'b1;
      tick();
      repeat (4) tick();
      seed      = 32'hFFFF_FFFF;
      start_req = 1'b1;
      inject    = 1'b1;
      used = 0;
      do begin
         tick();
         used++;
      end while (busy && used < 200);
      chk_eq("t4_run_ends", busy, 1'b0);
      chk_eq("t4_writes", n_wr, 16);
      chk_eq("t4_wdata3", wd3, 32'h5A59_0003);
      chk_eq("t4_err", err_count, 16'h0);
      chk_eq("t4_pass", pass, 1'b1);

      // Abort during reads with three outstanding
      reset_model();
      lat       = 6;
      abort_arm = 1'b1;
      run_to_idle(32'h0F0F_F0F0, 300);
      abort = 1'b0;
      chk_eq("t5_reads", n_rd, 3);
      chk_eq("t5_rsps", n_rsp, 3);
      chk_eq("t5_queue_empty", rq.size(), 0);
      chk_eq("t5_done", done, 1'b0);
      chk_eq("t5_pass", pass, 1'b0);
      chk_eq("t5_err", err_count, 16'h0);
      repeat (10) tick();
      chk_eq("t5_no_new_reqs", n_rd + n_wr, 16 + 3);
      chk_eq("t5_req_valid", req_valid, 1'b0);

      // Asynchronous reset during writes, then a clean run
      reset_model();
      lat       = 1;
      seed      = 32'h5555_AAAA;
      start_req = 1'b1;
      tick();
      repeat (4) tick();
      chk_eq("t6_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("t6_busy", busy, 1'b0);
      chk_eq("t6_req_valid", req_valid, 1'b0);
      chk_eq("t6_req_we", req_we, 1'b0);
      chk_eq("t6_req_addr", req_addr, 32'h0);
      chk_eq("t6_req_wdata", req_wdata, 32'h0);
      reset_model();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      reset_model();
      run_to_idle(32'hA5A5_0000, 200);
      chk_eq("t6_writes", n_wr, 16);
      chk_eq("t6_wdata3", wd3, 32'h5A59_0003);
      chk_eq("t6_pass", pass, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
